// File: rtl/axi_ace_snoop_multi_ctrl.sv
// Multi-master ACE snoop controller: broadcasts one AC request to a masked set of masters,
// collects every CR, drains every CD stream and returns the merged result with one captured line.
module axi_ace_snoop_multi_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned TIMEOUT     = 1024,
  localparam int unsigned SW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [3:0]                      req_snoop,
  input  logic [2:0]                      req_prot,
  input  logic [NUM_MASTERS-1:0]          req_mask,
  output logic [NUM_MASTERS-1:0]          ACVALID,
  input  logic [NUM_MASTERS-1:0]          ACREADY,
  output logic [ADDR_W-1:0]               ACADDR,
  output logic [3:0]                      ACSNOOP,
  output logic [2:0]                      ACPROT,
  input  logic [NUM_MASTERS-1:0]          CRVALID,
  output logic [NUM_MASTERS-1:0]          CRREADY,
  input  logic [5*NUM_MASTERS-1:0]        CRRESP,
  input  logic [NUM_MASTERS-1:0]          CDVALID,
  output logic [NUM_MASTERS-1:0]          CDREADY,
  input  logic [DATA_W*NUM_MASTERS-1:0]   CDDATA,
  input  logic [NUM_MASTERS-1:0]          CDLAST,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [4:0]                      rsp_crresp,
  output logic                            rsp_data_vld,
  output logic [DATA_W*BEATS-1:0]         rsp_line,
  output logic [SW-1:0]                   rsp_src,
  output logic                            rsp_err
);

  localparam int unsigned CW = $clog2(BEATS) + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] NBEATS = CW'(BEATS);
  localparam logic [CW-1:0] LASTB  = CW'(BEATS - 1);
  localparam logic [TW-1:0] TLIM   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_DATA, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [3:0]               snoop_q, snoop_d;
  logic [2:0]               prot_q, prot_d;
  logic [NUM_MASTERS-1:0]   mask_q, mask_d;
  logic [NUM_MASTERS-1:0]   acvalid_q, acvalid_d;
  logic [NUM_MASTERS-1:0]   ac_done_q, ac_done_d;
  logic [NUM_MASTERS-1:0]   cr_taken_q, cr_taken_d;
  logic [NUM_MASTERS-1:0]   pend_q, pend_d;
  logic [4:0]               crresp_q, crresp_d;
  logic                     err_q, err_d;
  logic                     dvld_q, dvld_d;
  logic [SW-1:0]            sel_q, sel_d;
  logic [DATA_W*BEATS-1:0]  line_q, line_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [CW-1:0]            cnt_q [NUM_MASTERS];
  logic [CW-1:0]            cnt_d [NUM_MASTERS];
  logic                     sel_found;
  logic                     tmo;

  // Timer holds TIMEOUT-1 in the cycle before DONE is forced, so rsp_valid lands TIMEOUT+1 after accept.
  assign tmo = (TIMEOUT != 0) && (timer_q == TLIM);

  assign req_ready    = (state_q == S_IDLE);
  assign ACVALID      = acvalid_q;
  assign ACADDR       = addr_q;
  assign ACSNOOP      = snoop_q;
  assign ACPROT       = prot_q;
  assign CRREADY      = (state_q == S_SNOOP) ? (ac_done_q & ~cr_taken_q) : '0;
  assign CDREADY      = (state_q == S_DATA) ? pend_q : '0;
  assign rsp_valid    = (state_q == S_DONE);
  assign rsp_crresp   = crresp_q;
  assign rsp_data_vld = dvld_q;
  assign rsp_line     = line_q;
  assign rsp_src      = sel_q;
  assign rsp_err      = err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    snoop_d    = snoop_q;
    prot_d     = prot_q;
    mask_d     = mask_q;
    acvalid_d  = acvalid_q;
    ac_done_d  = ac_done_q;
    cr_taken_d = cr_taken_q;
    pend_d     = pend_q;
    crresp_d   = crresp_q;
    err_d      = err_q;
    dvld_d     = dvld_q;
    sel_d      = sel_q;
    line_d     = line_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    sel_found  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          snoop_d    = req_snoop;
          prot_d     = req_prot;
          mask_d     = req_mask;
          acvalid_d  = req_mask;
          ac_done_d  = '0;
          cr_taken_d = '0;
          pend_d     = '0;
          crresp_d   = '0;
          err_d      = 1'b0;
          dvld_d     = 1'b0;
          sel_d      = '0;
          line_d     = '0;
          timer_d    = '0;
          for (int unsigned i = 0; i < NUM_MASTERS; i++) cnt_d[i] = '0;
          state_d    = (req_mask != '0) ? S_SNOOP : S_DONE;
        end
      end
      S_SNOOP: begin
        timer_d = timer_q + 1'b1;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          if (acvalid_q[i] && ACREADY[i]) begin
            acvalid_d[i] = 1'b0;
            ac_done_d[i] = 1'b1;
          end
          if (CRREADY[i] && CRVALID[i]) begin
            cr_taken_d[i] = 1'b1;
            crresp_d      = crresp_d | CRRESP[5*i +: 5];
            if (CRRESP[5*i])   pend_d[i] = 1'b1;
            if (CRRESP[5*i+1]) err_d     = 1'b1;
          end
        end
        if (cr_taken_d == mask_q) begin
          if (pend_d != '0) begin
            state_d = S_DATA;
            dvld_d  = 1'b1;
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
              if (pend_d[i] && !sel_found) begin
                sel_d     = SW'(i);
                sel_found = 1'b1;
              end
            end
          end else begin
            state_d = S_DONE;
          end
        end
        if (tmo) begin
          acvalid_d = '0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DATA: begin
        timer_d = timer_q + 1'b1;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          if (pend_q[i] && CDVALID[i]) begin
            if (SW'(i) == sel_q) begin
              for (int unsigned k = 0; k < BEATS; k++) begin
                if (cnt_q[i] == CW'(k)) line_d[DATA_W*k +: DATA_W] = CDDATA[DATA_W*i +: DATA_W];
              end
            end
            // Counter saturates at BEATS so overlong bursts are discarded until CDLAST.
            if (cnt_q[i] != NBEATS) cnt_d[i] = cnt_q[i] + 1'b1;
            if (CDLAST[i]) begin
              pend_d[i] = 1'b0;
              if (cnt_q[i] != LASTB) err_d = 1'b1;
            end else if (cnt_q[i] == LASTB) begin
              err_d = 1'b1;
            end
          end
        end
        if (pend_d == '0) state_d = S_DONE;
        if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      snoop_q    <= '0;
      prot_q     <= '0;
      mask_q     <= '0;
      acvalid_q  <= '0;
      ac_done_q  <= '0;
      cr_taken_q <= '0;
      pend_q     <= '0;
      crresp_q   <= '0;
      err_q      <= 1'b0;
      dvld_q     <= 1'b0;
      sel_q      <= '0;
      line_q     <= '0;
      timer_q    <= '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      snoop_q    <= snoop_d;
      prot_q     <= prot_d;
      mask_q     <= mask_d;
      acvalid_q  <= acvalid_d;
      ac_done_q  <= ac_done_d;
      cr_taken_q <= cr_taken_d;
      pend_q     <= pend_d;
      crresp_q   <= crresp_d;
      err_q      <= err_d;
      dvld_q     <= dvld_d;
      sel_q      <= sel_d;
      line_q     <= line_d;
      timer_q    <= timer_d;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_axi_ace_snoop_multi_ctrl.sv
// Directed bench for axi_ace_snoop_multi_ctrl: 4 masters, 8-bit beats, 4-beat lines, 16-cycle timeout.
module tb_axi_ace_snoop_multi_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BE = 4;

  logic            ACLK;
  logic            ARESETn;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic [3:0]      req_snoop;
  logic [2:0]      req_prot;
  logic [N-1:0]    req_mask;
  logic [N-1:0]    ACVALID;
  logic [N-1:0]    ACREADY;
  logic [31:0]     ACADDR;
  logic [3:0]      ACSNOOP;
  logic [2:0]      ACPROT;
  logic [N-1:0]    CRVALID;
  logic [N-1:0]    CRREADY;
  logic [5*N-1:0]  CRRESP;
  logic [N-1:0]    CDVALID;
  logic [N-1:0]    CDREADY;
  logic [DW*N-1:0] CDDATA;
  logic [N-1:0]    CDLAST;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_crresp;
  logic            rsp_data_vld;
  logic [DW*BE-1:0] rsp_line;
  logic [1:0]      rsp_src;
  logic            rsp_err;

  int total;
  int bad;
  int cnt3;
  int d [4];
  logic [N-1:0] expav;
  logic [N-1:0] expcr;

  axi_ace_snoop_multi_ctrl #(
    .ADDR_W(32), .DATA_W(DW), .NUM_MASTERS(N), .BEATS(BE), .TIMEOUT(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_snoop(req_snoop), .req_prot(req_prot), .req_mask(req_mask),
    .ACVALID(ACVALID), .ACREADY(ACREADY), .ACADDR(ACADDR), .ACSNOOP(ACSNOOP), .ACPROT(ACPROT),
    .CRVALID(CRVALID), .CRREADY(CRREADY), .CRRESP(CRRESP),
    .CDVALID(CDVALID), .CDREADY(CDREADY), .CDDATA(CDDATA), .CDLAST(CDLAST),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_crresp(rsp_crresp),
    .rsp_data_vld(rsp_data_vld), .rsp_line(rsp_line), .rsp_src(rsp_src), .rsp_err(rsp_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic rsp_handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, req_ready, 1);
    chk({tag, "_rspv_low"}, rsp_valid, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    ARESETn = 0; req_valid = 0; req_addr = 0; req_snoop = 0; req_prot = 0; req_mask = 0;
    ACREADY = 0; CRVALID = 0; CRRESP = 0; CDVALID = 0; CDDATA = 0; CDLAST = 0; rsp_ready = 0;
    tick(); tick();
    chk("rst_acvalid", ACVALID, 0);
    chk("rst_crready", CRREADY, 0);
    chk("rst_cdready", CDREADY, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_line", rsp_line, 0);
    ARESETn = 1;
    tick();
    chk("idle_req_ready", req_ready, 1);

    // T1: masters 1 and 2, M2 returns the line
    ACREADY = '1;
    req_valid = 1; req_addr = 32'hDEAD_BEE0; req_snoop = 4'h1; req_prot = 3'h2; req_mask = 4'b0110;
    tick();
    req_valid = 0;
    chk("t1_acvalid", ACVALID, 4'b0110);
    chk("t1_acaddr", ACADDR, 32'hDEAD_BEE0);
    chk("t1_acsnoop", ACSNOOP, 4'h1);
    chk("t1_acprot", ACPROT, 3'h2);
    chk("t1_req_ready_busy", req_ready, 0);
    chk("t1_crready_pre_ac", CRREADY, 0);
    CRVALID = 4'b0110; CRRESP[9:5] = 5'b01000; CRRESP[14:10] = 5'b00101;
    tick();
    chk("t1_ac_drop", ACVALID, 0);
    chk("t1_crready", CRREADY, 4'b0110);
    tick();
    CRVALID = 0; CRRESP = 0;
    chk("t1_cdready", CDREADY, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      CDVALID = 4'b0100; CDDATA[23:16] = 8'hA0 + 8'(k); CDLAST[2] = (k == 3);
      tick();
    end
    CDVALID = 0; CDLAST = 0;
    chk("t1_rspv", rsp_valid, 1);
    chk("t1_cdready_done", CDREADY, 0);
    tick(); tick();
    chk("t1_rspv_hold", rsp_valid, 1);
    chk("t1_crresp", rsp_crresp, 5'b01101);
    chk("t1_dvld", rsp_data_vld, 1);
    chk("t1_src", rsp_src, 2);
    chk("t1_line", rsp_line, 32'hA3A2A1A0);
    chk("t1_err", rsp_err, 0);
    rsp_handshake("t1");

    // T2: all masters, staggered ACREADY
    d[0] = 0; d[1] = 3; d[2] = 7; d[3] = 1;
    ACREADY = 0; CRVALID = 4'b1111; CRRESP = 0;
    req_valid = 1; req_mask = 4'b1111; req_addr = 32'h0000_1000;
    tick();
    req_valid = 0;
    for (int c = 1; c <= 10; c++) begin
      expav = 0; expcr = 0;
      for (int i = 0; i < 4; i++) begin
        expav[i] = (c <= d[i] + 1);
        expcr[i] = (c == d[i] + 2);
      end
      chk($sformatf("t2_acvalid_c%0d", c), ACVALID, expav);
      chk($sformatf("t2_crready_c%0d", c), CRREADY, expcr);
      chk($sformatf("t2_rspv_c%0d", c), rsp_valid, (c == 10));
      for (int i = 0; i < 4; i++) ACREADY[i] = (c >= d[i] + 1);
      if (c < 10) tick();
    end
    chk("t2_crresp", rsp_crresp, 0);
    chk("t2_dvld", rsp_data_vld, 0);
    chk("t2_err", rsp_err, 0);
    CRVALID = 0; ACREADY = '1;
    rsp_handshake("t2");

    // T3: M0 and M3 both return data; M3 sends 8 beats
    CRVALID = 4'b1001; CRRESP[4:0] = 5'b00001; CRRESP[19:15] = 5'b00001;
    req_valid = 1; req_mask = 4'b1001;
    tick();
    req_valid = 0;
    tick(); tick();
    CRVALID = 0; CRRESP = 0;
    chk("t3_cdready", CDREADY, 4'b1001);
    cnt3 = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) chk("t3_cdready_m0_done", CDREADY, 4'b1000);
      CDVALID[0] = (k < 4); CDDATA[7:0] = 8'h10 + 8'(k); CDLAST[0] = (k == 3);
      CDVALID[3] = 1'b1; CDDATA[31:24] = 8'hC0 + 8'(k); CDLAST[3] = (k == 7);
      if (CDVALID[3] && CDREADY[3]) cnt3++;
      tick();
    end
    CDVALID = 0; CDLAST = 0;
    chk("t3_m3_beats", cnt3, 8);
    chk("t3_rspv", rsp_valid, 1);
    chk("t3_line", rsp_line, 32'h13121110);
    chk("t3_src", rsp_src, 0);
    chk("t3_dvld", rsp_data_vld, 1);
    chk("t3_crresp", rsp_crresp, 5'b00001);
    chk("t3_err_m3_long", rsp_err, 1);
    rsp_handshake("t3");

    // T4: early CDLAST from selected master
    CRVALID = 4'b0100; CRRESP[14:10] = 5'b00001;
    req_valid = 1; req_mask = 4'b0100;
    tick();
    req_valid = 0;
    tick(); tick();
    CRVALID = 0; CRRESP = 0;
    for (int k = 0; k < 2; k++) begin
      CDVALID = 4'b0100; CDDATA[23:16] = 8'h50 + 8'(k); CDLAST[2] = (k == 1);
      tick();
    end
    CDVALID = 0; CDLAST = 0;
    chk("t4_rspv", rsp_valid, 1);
    chk("t4_line", rsp_line, 32'h00005150);
    chk("t4_err", rsp_err, 1);
    chk("t4_src", rsp_src, 2);
    rsp_handshake("t4");

    // T5: M2 never responds -> timeout
    req_valid = 1; req_mask = 4'b0100;
    tick();
    req_valid = 0;
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("t5_rspv_c%0d", c), rsp_valid, (c == 17));
      chk($sformatf("t5_crready_c%0d", c), CRREADY, (c >= 2 && c <= 16) ? 4'b0100 : 4'b0000);
      if (c < 17) tick();
    end
    chk("t5_err", rsp_err, 1);
    chk("t5_acvalid", ACVALID, 0);
    chk("t5_cdready", CDREADY, 0);
    chk("t5_dvld", rsp_data_vld, 0);
    rsp_handshake("t5");

    // T6a: empty mask
    req_valid = 1; req_mask = 4'b0000;
    tick();
    req_valid = 0;
    chk("t6_rspv", rsp_valid, 1);
    chk("t6_crresp", rsp_crresp, 0);
    chk("t6_dvld", rsp_data_vld, 0);
    chk("t6_line", rsp_line, 0);
    chk("t6_src", rsp_src, 0);
    chk("t6_err", rsp_err, 0);
    chk("t6_acvalid", ACVALID, 0);
    rsp_handshake("t6");

    // T6b: reset asserted mid-DATA
    CRVALID = 4'b0010; CRRESP[9:5] = 5'b00001;
    req_valid = 1; req_mask = 4'b0010;
    tick();
    req_valid = 0;
    tick(); tick();
    CRVALID = 0; CRRESP = 0;
    chk("t6r_cdready", CDREADY, 4'b0010);
    CDVALID = 4'b0010; CDDATA[15:8] = 8'h77;
    tick();
    CDVALID = 0;
    ARESETn = 0;
    tick();
    chk("t6r_acvalid", ACVALID, 0);
    chk("t6r_crready", CRREADY, 0);
    chk("t6r_cdready", CDREADY, 0);
    chk("t6r_rspv", rsp_valid, 0);
    chk("t6r_line", rsp_line, 0);
    chk("t6r_err", rsp_err, 0);
    chk("t6r_dvld", rsp_data_vld, 0);
    chk("t6r_crresp", rsp_crresp, 0);
    ARESETn = 1;
    tick();
    chk("t6r_req_ready", req_ready, 1);
    chk("t6r_rspv_after", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
